// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, default width
// and the round-robin search used to pick the next requester.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int MAX_REQ       = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid requester after 'last', wrapping modulo 'num' (num <= MAX_REQ).
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         last,
                                         input logic [3:0]         num);
    rr_pick_t   pick;
    logic [3:0] cand;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = {1'b0, last} + 4'(k);
      if (cand >= num) cand = cand - num;
      if (!pick.found && (4'(k) <= num) && valid[cand[2:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational signed WIDTH x WIDTH multiplier with full-width product and a
// flag for products that do not fit in a signed WIDTH-bit value.
module multiplier #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ovr,
  output logic [2*WIDTH-1:0] product
);

  logic signed [2*WIDTH-1:0] w_a_ext;
  logic signed [2*WIDTH-1:0] w_b_ext;
  logic        [WIDTH:0]     w_top;

  assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign product = w_a_ext * w_b_ext;

  // The product fits only if its upper half plus the low sign bit are all equal.
  assign w_top = product[2*WIDTH-1:WIDTH-1];
  assign ovr   = !((&w_top) || (~|w_top));

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one signed multiplier between NUM_REQ requesters;
// operands are registered so the multiplier gets a whole cycle to settle.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     resp_ovr,
  output state_t                   o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; requesters hold valid and operands until that edge, and the
  // response stays stable from resp_valid rising until resp_ready takes it.

  state_t             r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [ID_W-1:0]    r_id_q;
  logic [ID_W-1:0]    r_last_grant;
  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [2*WIDTH-1:0] r_resp_product;
  logic               r_resp_ovr;

  logic [MAX_REQ-1:0] w_valid_ext;
  rr_pick_t           w_pick;
  logic [ID_W-1:0]    w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a_arr [NUM_REQ];
  logic [WIDTH-1:0]   w_b_arr [NUM_REQ];
  logic [2*WIDTH-1:0] w_product;
  logic               w_ovr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  assign w_valid_ext = MAX_REQ'(req_valid);
  assign w_pick      = rr_search(w_valid_ext, 3'(r_last_grant), 4'(NUM_REQ));
  assign w_grant     = ID_W'(w_pick.idx);
  assign w_accept    = (r_state == IDLE) && w_pick.found;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  multiplier #(
    .WIDTH (WIDTH)
  ) u_multiplier (
    .a       (r_op_a),
    .b       (r_op_b),
    .ovr     (w_ovr),
    .product (w_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_id_q         <= '0;
      r_last_grant   <= ID_W'(NUM_REQ - 1);
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_product <= '0;
      r_resp_ovr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a       <= w_a_arr[w_grant];
            r_op_b       <= w_b_arr[w_grant];
            r_id_q       <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_resp_product <= w_product;
          r_resp_ovr     <= w_ovr;
          r_resp_id      <= r_id_q;
          r_resp_valid   <= 1'b1;
          r_state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_product = r_resp_product;
  assign resp_ovr     = r_resp_ovr;
  assign o_dbg_state  = r_state;

endmodule
